// File: rtl/conv_pkg.sv
// Shared definitions for the conv array feed controller: FSM states,
// bus count and default geometry/width constants.
package conv_pkg;

    localparam int unsigned K             = 3;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned MAX_W_DEF     = 64;
    localparam int unsigned MAX_H_DEF     = 64;
    localparam int unsigned DRAIN_CYC_DEF = 5;
    localparam int unsigned COL_W_DEF     = $clog2(MAX_W_DEF);
    localparam int unsigned ROW_W_DEF     = $clog2(MAX_H_DEF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_WAIT_RDY,
        S_DONE
    } conv_state_e;

    // Width of a counter that must hold values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_feed_ctrl_if.sv
// Bank-read and input-bus signals between the feed controller (master)
// and the row-banked memories plus the three array input buses (slave).
interface conv_feed_ctrl_if #(
    parameter int unsigned DATA_W = conv_pkg::DATA_W_DEF,
    parameter int unsigned COL_W  = conv_pkg::COL_W_DEF,
    parameter int unsigned ROW_W  = conv_pkg::ROW_W_DEF
) ();

    logic              rd_en;
    logic [COL_W-1:0]  rd_col;
    logic [ROW_W-1:0]  rd_row0;
    logic [ROW_W-1:0]  rd_row1;
    logic [ROW_W-1:0]  rd_row2;
    logic [DATA_W-1:0] rd_data0;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              bus_en0;
    logic              bus_en1;
    logic              bus_en2;
    logic [DATA_W-1:0] bus_data0;
    logic [DATA_W-1:0] bus_data1;
    logic [DATA_W-1:0] bus_data2;

    modport master (
        output rd_en, rd_col, rd_row0, rd_row1, rd_row2,
        input  rd_data0, rd_data1, rd_data2,
        output bus_en0, bus_en1, bus_en2,
        output bus_data0, bus_data1, bus_data2
    );

    modport slave (
        input  rd_en, rd_col, rd_row0, rd_row1, rd_row2,
        output rd_data0, rd_data1, rd_data2,
        input  bus_en0, bus_en1, bus_en2,
        input  bus_data0, bus_data1, bus_data2
    );

endinterface

// File: rtl/conv_scan_cnt.sv
// Column, output-row and drain counters for the feed scan, with terminal
// flags against the latched frame geometry. Counters saturate, never wrap.
module conv_scan_cnt #(
    parameter int unsigned COL_W     = conv_pkg::COL_W_DEF,
    parameter int unsigned ROW_W     = conv_pkg::ROW_W_DEF,
    parameter int unsigned DRAIN_CYC = conv_pkg::DRAIN_CYC_DEF,
    parameter int unsigned DRN_W     = conv_pkg::cnt_w(DRAIN_CYC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [COL_W:0]   cfg_w,
    input  logic [ROW_W:0]   cfg_h,
    input  logic             col_clr,
    input  logic             col_inc,
    input  logic             row_clr,
    input  logic             row_inc,
    input  logic             drn_clr,
    input  logic             drn_inc,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             col_last,
    output logic             row_last,
    output logic             drn_last
);

    localparam logic [COL_W:0]   COL_ONE  = 1;
    localparam logic [ROW_W:0]   ROW_THREE = 3;
    localparam logic [DRN_W-1:0] DRN_TERM = DRN_W'(DRAIN_CYC - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [DRN_W-1:0] drn_q, drn_d;

    always_comb begin
        col_last = ({1'b0, col_q} == (cfg_w - COL_ONE));
        row_last = ({1'b0, row_q} == (cfg_h - ROW_THREE));
        drn_last = (drn_q == DRN_TERM);

        col_d = col_q;
        if (col_clr)
            col_d = '0;
        else if (col_inc && !col_last)
            col_d = col_q + 1'b1;

        row_d = row_q;
        if (row_clr)
            row_d = '0;
        else if (row_inc && !row_last)
            row_d = row_q + 1'b1;

        drn_d = drn_q;
        if (drn_clr)
            drn_d = '0;
        else if (drn_inc && !drn_last)
            drn_d = drn_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            drn_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            drn_q <= drn_d;
        end
    end

    assign col = col_q;
    assign row = row_q;

endmodule

// File: rtl/conv_feed_ctrl.sv
// Feed sequencer for the three row input buses of the 3x3 conv array:
// scans one output row at a time, drains the array, waits for downstream.
module conv_feed_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_W     = MAX_W_DEF,
    parameter int unsigned MAX_H     = MAX_H_DEF,
    parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int unsigned COL_W     = $clog2(MAX_W),
    parameter int unsigned ROW_W     = $clog2(MAX_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [COL_W:0]   cfg_w,
    input  logic [ROW_W:0]   cfg_h,
    input  logic             row_ready,
    conv_feed_ctrl_if.master fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             aborted,
    output logic             row_done,
    output logic [ROW_W-1:0] row_idx
);

    localparam logic [COL_W:0] W_MIN = 3;
    localparam logic [COL_W:0] W_MAX = (COL_W + 1)'(MAX_W);
    localparam logic [ROW_W:0] H_MIN = 3;
    localparam logic [ROW_W:0] H_MAX = (ROW_W + 1)'(MAX_H);

    conv_state_e state_q, state_d;
    logic [COL_W:0] cfg_w_q, cfg_w_d;
    logic [ROW_W:0] cfg_h_q, cfg_h_d;
    logic           bus_en_q, bus_en_d;
    logic           err_q, err_d;
    logic           aborted_q, aborted_d;

    logic             rd_en;
    logic             cfg_ok;
    logic             col_clr, col_inc, row_clr, row_inc, drn_clr, drn_inc;
    logic             col_last, row_last, drn_last;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    conv_scan_cnt #(
        .COL_W     (COL_W),
        .ROW_W     (ROW_W),
        .DRAIN_CYC (DRAIN_CYC)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .cfg_w    (cfg_w_q),
        .cfg_h    (cfg_h_q),
        .col_clr  (col_clr),
        .col_inc  (col_inc),
        .row_clr  (row_clr),
        .row_inc  (row_inc),
        .drn_clr  (drn_clr),
        .drn_inc  (drn_inc),
        .col      (col),
        .row      (row),
        .col_last (col_last),
        .row_last (row_last),
        .drn_last (drn_last)
    );

    assign cfg_ok = (cfg_w >= W_MIN) && (cfg_w <= W_MAX) &&
                    (cfg_h >= H_MIN) && (cfg_h <= H_MAX);

    always_comb begin
        state_d   = state_q;
        cfg_w_d   = cfg_w_q;
        cfg_h_d   = cfg_h_q;
        err_d     = 1'b0;
        aborted_d = 1'b0;
        rd_en     = 1'b0;
        row_done  = 1'b0;
        done      = 1'b0;
        col_clr   = 1'b0;
        col_inc   = 1'b0;
        row_clr   = 1'b0;
        row_inc   = 1'b0;
        drn_clr   = 1'b0;
        drn_inc   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_w_d = cfg_w;
                    cfg_h_d = cfg_h;
                    if (cfg_ok) begin
                        col_clr = 1'b1;
                        row_clr = 1'b1;
                        state_d = S_STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                rd_en   = 1'b1;
                col_inc = 1'b1;
                if (col_last) begin
                    drn_clr = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drn_inc = 1'b1;
                if (drn_last) begin
                    row_done = 1'b1;
                    if (row_last) begin
                        state_d = S_DONE;
                    end else begin
                        row_inc = 1'b1;
                        col_clr = 1'b1;
                        state_d = row_ready ? S_STREAM : S_WAIT_RDY;
                    end
                end
            end
            S_WAIT_RDY: begin
                if (row_ready)
                    state_d = S_STREAM;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything decided above, including this cycle's strobes.
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
            rd_en     = 1'b0;
            row_done  = 1'b0;
            done      = 1'b0;
            col_clr   = 1'b0;
            col_inc   = 1'b0;
            row_inc   = 1'b0;
            drn_clr   = 1'b0;
            drn_inc   = 1'b0;
        end

        bus_en_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cfg_w_q   <= '0;
            cfg_h_q   <= '0;
            bus_en_q  <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_w_q   <= cfg_w_d;
            cfg_h_q   <= cfg_h_d;
            bus_en_q  <= bus_en_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign err     = err_q;
    assign aborted = aborted_q;
    assign row_idx = row;

    // Addresses read as zero while idle so the reset view is all-zero.
    assign fb.rd_en   = rd_en;
    assign fb.rd_col  = busy ? col : '0;
    assign fb.rd_row0 = busy ? row : '0;
    assign fb.rd_row1 = busy ? row + ROW_W'(1) : '0;
    assign fb.rd_row2 = busy ? row + ROW_W'(2) : '0;

    assign fb.bus_en0   = bus_en_q;
    assign fb.bus_en1   = bus_en_q;
    assign fb.bus_en2   = bus_en_q;
    assign fb.bus_data0 = fb.rd_data0;
    assign fb.bus_data1 = fb.rd_data1;
    assign fb.bus_data2 = fb.rd_data2;

endmodule

// File: tb/tb_conv_feed_ctrl.sv
// Scoreboard bench for conv_feed_ctrl: bank model, expected bus beats and
// row indices queued at start, compared as the buses produce them.
module tb_conv_feed_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned MW = 64;
    localparam int unsigned MH = 64;
    localparam int unsigned DC = 5;
    localparam int unsigned CW = 6;
    localparam int unsigned RW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          row_ready = 1'b1;
    logic [CW:0]   cfg_w = '0;
    logic [RW:0]   cfg_h = '0;
    logic          busy, done, err, aborted, row_done;
    logic [RW-1:0] row_idx;

    conv_feed_ctrl_if #(.DATA_W(DW), .COL_W(CW), .ROW_W(RW)) fb ();

    conv_feed_ctrl #(
        .DATA_W    (DW),
        .MAX_W     (MW),
        .MAX_H     (MH),
        .DRAIN_CYC (DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cfg_w     (cfg_w),
        .cfg_h     (cfg_h),
        .row_ready (row_ready),
        .fb        (fb),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .aborted   (aborted),
        .row_done  (row_done),
        .row_idx   (row_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } beat_t;

    beat_t         sb_q[$];
    logic [RW-1:0] row_q[$];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int cyc = 0;
    int rd_en_cnt = 0, n_beats = 0, row_done_cnt = 0;
    int done_cnt = 0, err_cnt = 0, aborted_cnt = 0;
    int done_cyc = 0, first_rd = -1, first_ben = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int r, input int c);
        return DW'(r * 16 + c);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Row-banked memories: one-cycle read latency.
    always @(posedge clk) begin
        if (fb.rd_en) begin
            fb.rd_data0 <= pix(int'(fb.rd_row0), int'(fb.rd_col));
            fb.rd_data1 <= pix(int'(fb.rd_row1), int'(fb.rd_col));
            fb.rd_data2 <= pix(int'(fb.rd_row2), int'(fb.rd_col));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (fb.bus_en0) begin
                n_beats++;
                if (first_ben < 0) first_ben = cyc;
                check("bus_en12", {fb.bus_en1, fb.bus_en2}, 2'b11);
                check("beat_expected", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    beat_t b;
                    b = sb_q.pop_front();
                    check("bus_data0", fb.bus_data0, b.d0);
                    check("bus_data1", fb.bus_data1, b.d1);
                    check("bus_data2", fb.bus_data2, b.d2);
                end
            end
            if (row_done) begin
                row_done_cnt++;
                check("row_expected", row_q.size() > 0, 1);
                if (row_q.size() > 0) check("row_idx", row_idx, row_q.pop_front());
            end
            if (fb.rd_en) begin
                rd_en_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err) err_cnt++;
            if (aborted) aborted_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic go(input int w, input int h, output int t0);
        cfg_w = (CW + 1)'(w);
        cfg_h = (RW + 1)'(h);
        start = 1'b1;
        first_rd = -1;
        first_ben = -1;
        t0 = cyc;
        if (w >= 3 && w <= int'(MW) && h >= 3 && h <= int'(MH)) begin
            for (int r = 0; r <= h - 3; r++) begin
                row_q.push_back(RW'(r));
                for (int c = 0; c < w; c++)
                    sb_q.push_back('{pix(r, c), pix(r + 1, c), pix(r + 2, c)});
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int base);
        int k = 0;
        while (done_cnt == base && k < budget) begin
            tick();
            k++;
        end
        check("done_seen", done_cnt, base + 1);
    endtask

    task automatic wait_rows(input int target, input int budget);
        int k = 0;
        while (row_done_cnt < target && k < budget) begin
            tick();
            k++;
        end
        check("row_done_seen", row_done_cnt, target);
    endtask

    task automatic flush();
        sb_q.delete();
        row_q.delete();
    endtask

    initial begin
        int t0, d0, r0, b0, rd0, e0, a0;

        repeat (3) tick();
        check("rst_outputs", {busy, done, err, aborted, row_done, fb.rd_en, fb.bus_en0},
              7'b0);
        check("rst_addr", {fb.rd_col, fb.rd_row0, fb.rd_row2, row_idx}, '0);
        rst = 1'b0;
        tick();

        // Single-row frame 4x3
        d0 = done_cnt; r0 = rd_en_cnt; b0 = n_beats; rd0 = row_done_cnt;
        go(4, 3, t0);
        wait_done(100, d0);
        check("f1_latency", done_cyc - t0, 10);
        check("f1_rd_en_cnt", rd_en_cnt - r0, 4);
        check("f1_first_rd", first_rd - t0, 1);
        check("f1_first_ben", first_ben - t0, 2);
        check("f1_beats", n_beats - b0, 4);
        check("f1_rows", row_done_cnt - rd0, 1);
        check("f1_sb_empty", sb_q.size() + row_q.size(), 0);
        tick();
        check("f1_idle", busy, 1'b0);

        // 5x6 frame
        d0 = done_cnt; b0 = n_beats; rd0 = row_done_cnt;
        go(5, 6, t0);
        wait_done(200, d0);
        check("f2_latency", done_cyc - t0, 41);
        check("f2_beats", n_beats - b0, 20);
        check("f2_rows", row_done_cnt - rd0, 4);
        check("f2_sb_empty", sb_q.size() + row_q.size(), 0);
        tick();

        // Back-pressure after row 1
        d0 = done_cnt; rd0 = row_done_cnt;
        go(4, 6, t0);
        wait_rows(rd0 + 1, 100);
        tick(); tick();
        row_ready = 1'b0;
        wait_rows(rd0 + 2, 100);
        repeat (4) tick();
        check("wait_busy", busy, 1'b1);
        check("wait_rd_en", fb.rd_en, 1'b0);
        check("wait_bus_en", fb.bus_en0, 1'b0);
        row_ready = 1'b1;
        tick();
        check("resume_rd_en", fb.rd_en, 1'b1);
        check("resume_row", fb.rd_row0, 2);
        check("resume_col", fb.rd_col, 0);
        wait_done(200, d0);
        check("f3_rows", row_done_cnt - rd0, 4);
        check("f3_sb_empty", sb_q.size() + row_q.size(), 0);
        tick();

        // Invalid configurations
        e0 = err_cnt; r0 = rd_en_cnt;
        go(2, 4, t0);
        repeat (3) tick();
        check("bad_w_err", err_cnt - e0, 1);
        check("bad_w_busy", busy, 1'b0);
        check("bad_w_rd", rd_en_cnt - r0, 0);
        e0 = err_cnt;
        go(4, int'(MH) + 1, t0);
        repeat (3) tick();
        check("bad_h_err", err_cnt - e0, 1);
        check("bad_h_busy", busy, 1'b0);
        check("bad_h_rd", rd_en_cnt - r0, 0);

        // Abort on the third STREAM clk of row 1
        d0 = done_cnt; a0 = aborted_cnt; rd0 = row_done_cnt;
        go(6, 5, t0);
        wait_rows(rd0 + 1, 100);
        repeat (3) tick();
        check("pre_abort_rd", {fb.rd_en, fb.rd_col}, {1'b1, 6'd2});
        abort = 1'b1;
        #1;
        check("abort_rd_en", fb.rd_en, 1'b0);
        tick();
        abort = 1'b0;
        check("aborted_pulse", aborted_cnt - a0, 1);
        check("abort_busy", busy, 1'b0);
        check("abort_bus_en", fb.bus_en0, 1'b0);
        repeat (10) tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("aborted_once", aborted_cnt - a0, 1);
        flush();
        d0 = done_cnt;
        go(3, 3, t0);
        wait_done(100, d0);
        check("post_abort_latency", done_cyc - t0, 9);
        check("post_abort_sb", sb_q.size() + row_q.size(), 0);
        tick();

        // Reset mid-DRAIN
        d0 = done_cnt; a0 = aborted_cnt;
        go(4, 4, t0);
        repeat (6) tick();
        check("pre_rst_drain", {busy, fb.rd_en}, 2'b10);
        rst = 1'b1;
        tick();
        check("mid_rst_outputs",
              {busy, done, err, aborted, row_done, fb.rd_en, fb.bus_en0}, 7'b0);
        check("mid_rst_addr", {fb.rd_col, fb.rd_row0, fb.rd_row2, row_idx}, '0);
        rst = 1'b0;
        flush();
        go(4, 4, t0);
        wait_done(200, d0);
        check("post_rst_latency", done_cyc - t0, 19);
        check("post_rst_sb", sb_q.size() + row_q.size(), 0);
        check("post_rst_no_abort", aborted_cnt - a0, 0);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_feed_ctrl.md
# conv_feed_ctrl

Sequencing controller for the three row input buses of the 3x3 conv systolic array. It scans an input feature map held in three row-banked memories, one output row at a time. For each column it issues one read per bank and drives the returned pixels, with aligned enables, onto the heads of the three input buses. The buses then apply their own 0/1/2-clk skew toward the PEs. Between output rows it drains the array and waits for the downstream accumulator to accept.

## Interface
- DATA_W, 8, pixel width (matches input bus BUS_WIDTH)
- MAX_W, 64, max feature-map width; COL_W = clog2(MAX_W)
- MAX_H, 64, max feature-map height; ROW_W = clog2(MAX_H)
- DRAIN_CYC, 5, flush cycles after last column of a row (2 bus skew + 3 PE stages)
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a frame; sampled only in IDLE
- abort  input  1  terminate current frame
- cfg_w  input  COL_W+1  frame width, latched on accepted start
- cfg_h  input  ROW_W+1  frame height, latched on accepted start
- row_ready  input  1  downstream can take the next output row
- rd_en  output  1  read strobe to all three banks
- rd_col  output  COL_W  column address, shared
- rd_row0/1/2  output  ROW_W each  row address per bank (r, r+1, r+2)
- rd_data0/1/2  input  DATA_W each  bank read data, valid 1 clk after rd_en
- bus_en0/1/2  output  1 each  enable into input bus k
- bus_data0/1/2  output  DATA_W each  data into input bus k
- busy, done, err, aborted, row_done  output  1  status; done/err/aborted/row_done are 1-clk pulses
- row_idx  output  ROW_W  output row index, valid with row_done

## Operation
- States are IDLE, STREAM, DRAIN, WAIT_RDY and DONE.
- **IDLE**
  - On start, the block latches cfg.
  - If 3<=cfg_w<=MAX_W and 3<=cfg_h<=MAX_H, it sets r=0, c=0 and goes to STREAM.
  - Otherwise it pulses err for 1 clk and stays in IDLE.
- **STREAM**
  - rd_en=1, rd_col=c, rd_rowk=r+k.
  - c increments each clk. At c=cfg_w-1 the block goes to DRAIN with a drain counter of 0.
- **DRAIN**
  - rd_en=0. The counter runs to DRAIN_CYC-1.
  - On the last drain cycle, row_done pulses with row_idx=r.
  - If r=cfg_h-3, the block goes to DONE. Otherwise r increments, c=0, and it goes to STREAM if row_ready, else WAIT_RDY.
- **WAIT_RDY**: goes to STREAM on the first clk with row_ready=1.
- **DONE**: done pulses and the block returns to IDLE.
- The output-row count per frame is cfg_h-2. Each row streams exactly cfg_w columns.
- bus_datak is rd_datak passed through combinationally. bus_enk is rd_en registered by 1 clk.
- busy=1 in every state except IDLE.
- start while busy is ignored.
- **abort**
  - Takes effect in any non-IDLE state: the next state is IDLE, and rd_en is forced to 0 in the same cycle.
  - aborted pulses on the following clk and done is not pulsed.
  - bus_en drops 1 clk later through the normal pipeline.
- abort has priority over every other transition.
- **Reset value**
  - Outputs: all status pulses 0, busy 0, rd_en 0, bus_en 0, addresses 0, row_idx 0. bus_data follows rd_data, which is don't-care.
  - State: IDLE.

## Timing
- Start accepted at edge T: rd_en=1 from T+1, with col 0.
- bus_en0..2 are high from T+2 for cfg_w cycles, carrying pixels (r+k, 0..cfg_w-1).
- Per-row cost with row_ready held high is cfg_w+DRAIN_CYC clks.
- Frame latency, from accepted start to the done pulse, is 1+(cfg_h-2)(cfg_w+DRAIN_CYC) clks.
- row_ready is sampled only on the last DRAIN cycle and in WAIT_RDY.
- The downstream consumer must hold row_ready until the next row starts streaming.
- **Reset mid-frame**: on the edge where rst=1, the block returns to IDLE with all outputs at reset values. No done or aborted pulse is produced.
- Counters never wrap. rd_row2 is at most cfg_h-1 and rd_col is at most cfg_w-1.

## Structure
- Shared package conv_pkg holds:
  - the state enum
  - K=3
  - default DATA_W
  - DRAIN_CYC default
  - the clog2-based width constants
- Sub-module conv_scan_cnt holds the column, row and drain counters, with terminal-count flags. The FSM and output logic stay in conv_feed_ctrl.

## Test plan
- Reset, then a valid start with cfg_w=4, cfg_h=3 and row_ready=1 held high:
  - exactly 4 rd_en clks
  - bus_en high for 4 clks starting at T+2
  - one row_done with row_idx=0
  - done at T+10
- cfg_w=5, cfg_h=6, banks preloaded with pixel=row*16+col:
  - 4 rows, each with 5 bus beats
  - bus_data2 on row 3 = 0x50..0x54
  - done after 1+4*10=41 clks
- cfg_h=6 with row_ready=0 after row 1:
  - the block holds in WAIT_RDY with busy=1 and rd_en=0
  - raising row_ready resumes at r=2, c=0
- Invalid configurations:
  - cfg_w=2 gives an err pulse, busy stays 0 and there is no rd_en
  - cfg_h=MAX_H+1 likewise gives err
- abort on the 3rd STREAM clk of row 1:
  - rd_en is 0 that cycle
  - aborted pulses next clk
  - no done
  - a new start is accepted afterwards
- rst asserted mid-DRAIN:
  - all outputs at reset values on the next clk
  - an immediate start runs a full frame correctly
